// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    SCAN_BLANK,
    SCAN_ON,
    SCAN_OFF
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Width that holds (CLK_DIV-BLANK_CYC)*(2^bright_w) plus BLANK_CYC without overflow.
  function automatic int on_len_width(input int clk_div, input int bright_w);
    return $clog2(clk_div + 1) + bright_w + 1;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to common-cathode 7-segment decoder, {a,b,c,d,e,f,g} active-high.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (en) begin
      case (bcd)
        4'd0:    seg = 7'b1111110;
        4'd1:    seg = 7'b0110000;
        4'd2:    seg = 7'b1101101;
        4'd3:    seg = 7'b1111001;
        4'd4:    seg = 7'b0110011;
        4'd5:    seg = 7'b1011011;
        4'd6:    seg = 7'b1011111;
        4'd7:    seg = 7'b1110000;
        4'd8:    seg = 7'b1111111;
        4'd9:    seg = 7'b1111011;
        default: seg = SEG_BLANK;  // A-F render dark
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans N_DIGITS digits through one shared decoder with blanking, PWM brightness,
// leading-zero suppression and a frame-synchronous double-buffered digit load.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 256,
  parameter int BLANK_CYC = 8,
  parameter int BRIGHT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  output logic                  load_ack,
  input  logic                  display_en,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_start
);

  localparam int CYC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIG_W = $clog2(N_DIGITS);
  localparam int OL_W  = on_len_width(CLK_DIV, BRIGHT_W);
  localparam int DW    = 4 * N_DIGITS;
  localparam logic [N_DIGITS-1:0] SEL_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  if (CLK_DIV <= BLANK_CYC) begin : g_bad_cfg
    $error("display_scan_ctrl: CLK_DIV must exceed BLANK_CYC");
  end

  logic [CYC_W-1:0]    cyc;
  logic [DIG_W-1:0]    dig;
  logic                cyc_wrap, dig_wrap, boundary;
  logic [BRIGHT_W-1:0] bright_q, bright_eff;
  logic [OL_W-1:0]     on_prod, on_len, cyc_ext;
  scan_state_t         scan_state;
  logic [DW-1:0]       active_buf, pending_buf;
  logic                pending_flag, ack_due;
  logic [N_DIGITS-1:0] lz_blanked;
  logic                zero_above;
  logic [3:0]          cur_bcd;
  logic [6:0]          dec_seg;

  assign cyc_wrap = (cyc == CYC_W'(CLK_DIV - 1));
  assign dig_wrap = (dig == DIG_W'(N_DIGITS - 1));
  assign boundary = cyc_wrap & dig_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc      <= '0;
      dig      <= '0;
      bright_q <= '0;
    end else begin
      cyc <= cyc_wrap ? '0 : cyc + 1'b1;
      if (cyc_wrap) dig <= dig_wrap ? '0 : dig + 1'b1;
      if (cyc == '0) bright_q <= brightness;
    end
  end

  // Brightness is taken live on cyc 0 and held for the rest of the slot.
  assign bright_eff = (cyc == '0) ? brightness : bright_q;
  assign on_prod    = OL_W'(CLK_DIV - BLANK_CYC) * (OL_W'(bright_eff) + OL_W'(1));
  assign on_len     = on_prod >> BRIGHT_W;
  assign cyc_ext    = OL_W'(cyc);

  // Slot phase is decoded purely from the slot counter; no separate state register.
  always_comb begin
    scan_state = SCAN_OFF;
    if (cyc_ext < OL_W'(BLANK_CYC))
      scan_state = SCAN_BLANK;
    else if (cyc_ext < OL_W'(BLANK_CYC) + on_len)
      scan_state = SCAN_ON;
  end

  always_comb begin
    lz_blanked = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (active_buf[4*k +: 4] == 4'd0);
      lz_blanked[k] = lz_blank & zero_above;
    end
  end

  assign cur_bcd = active_buf[{dig, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_bcd),
    .en  (~lz_blanked[dig]),
    .seg (dec_seg)
  );

  // A load landing on the boundary cycle bypasses the pending buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_buf   <= '0;
      pending_buf  <= '0;
      pending_flag <= 1'b0;
      ack_due      <= 1'b0;
    end else begin
      ack_due <= 1'b0;
      if (boundary) begin
        if (load) begin
          active_buf   <= digits_in;
          pending_flag <= 1'b0;
          ack_due      <= 1'b1;
        end else if (pending_flag) begin
          active_buf   <= pending_buf;
          pending_flag <= 1'b0;
          ack_due      <= 1'b1;
        end
      end else if (load) begin
        pending_buf  <= digits_in;
        pending_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
      digit_sel   <= '0;
      seg_out     <= SEG_BLANK;
    end else begin
      frame_start <= (cyc == '0) && (dig == '0);
      load_ack    <= ack_due;
      if (scan_state == SCAN_ON && display_en) begin
        digit_sel <= SEL_ONE << dig;
        seg_out   <= dec_seg;
      end else begin
        digit_sel <= '0;
        seg_out   <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, CLK_DIV=16, BLANK_CYC=2, BRIGHT_W=4.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic        load;
  logic        load_ack;
  logic        display_en;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int compared   = 0;
  int mismatched = 0;
  int t          = 0;
  int ack_cnt    = 0;
  int n          = 0;
  logic [10:0] lit_acc = '0;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;

  display_scan_ctrl #(
    .N_DIGITS(4), .CLK_DIV(16), .BLANK_CYC(2), .BRIGHT_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .load        (load),
    .load_ack    (load_ack),
    .display_en  (display_en),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .seg_out     (seg_out),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    if (load_ack === 1'b1) ack_cnt++;
    lit_acc = lit_acc | {digit_sel, seg_out};
  endtask

  task automatic step_to(input int target);
    while (t < target) step();
  endtask

  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (frame_start !== 1'b1 && cnt < 200);
    check("frame_start_seen", 32'(frame_start), 32'd1);
    t = 0;
  endtask

  task automatic pulse_load(input logic [15:0] val);
    load = 1'b1;
    digits_in = val;
    step();
    load = 1'b0;
  endtask

  task automatic check_pins(input string tag, input logic [3:0] sel, input logic [6:0] seg);
    check({tag, "_sel"}, 32'(digit_sel), 32'(sel));
    check({tag, "_seg"}, 32'(seg_out), 32'(seg));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = '0;
    display_en = 1'b0; lz_blank = 1'b0; brightness = '0;
    repeat (3) @(negedge clk);
    check_pins("reset", 4'b0000, 7'b0);
    check("reset_fs", 32'(frame_start), 32'd0);
    check("reset_ack", 32'(load_ack), 32'd0);

    brightness = 4'd15; display_en = 1'b1;
    reset = 1'b0;
    wait_fs(n);
    check("first_fs_latency", 32'(n), 32'd1);

    // Basic load and scan at full brightness
    pulse_load(16'h1234);
    wait_fs(n);
    check("t1_ack_t0", 32'(load_ack), 32'd1);
    check_pins("t1_t0", 4'b0000, 7'b0);
    step_to(1);  check("t1_ack_t1", 32'(load_ack), 32'd0);
    check_pins("t1_t1", 4'b0000, 7'b0);
    step_to(2);  check_pins("t1_t2", 4'b0001, S4);
    step_to(15); check_pins("t1_t15", 4'b0001, S4);
    step_to(16); check_pins("t1_t16", 4'b0000, 7'b0);
    step_to(17); check_pins("t1_t17", 4'b0000, 7'b0);
    step_to(18); check_pins("t1_t18", 4'b0010, S3);
    step_to(31); check_pins("t1_t31", 4'b0010, S3);

    // PWM: brightness 7 gives on_len 7
    brightness = 4'd7;
    wait_fs(n);
    check("fs_period_a", 32'(n), 32'd33);
    step_to(2);  check_pins("t2_t2", 4'b0001, S4);
    step_to(8);  check_pins("t2_t8", 4'b0001, S4);
    step_to(9);  check_pins("t2_t9", 4'b0000, 7'b0);
    step_to(15); check_pins("t2_t15", 4'b0000, 7'b0);
    brightness = 4'd0;
    lit_acc = '0;
    wait_fs(n);
    step_to(63);
    check("t2_bright0_sel", 32'(lit_acc[10:7]), 32'd0);

    // Leading-zero blanking
    brightness = 4'd15; lz_blank = 1'b1;
    wait_fs(n);
    step_to(5); pulse_load(16'h0045);
    wait_fs(n);
    check("t3_ack", 32'(load_ack), 32'd1);
    step_to(2);  check_pins("t3_d0", 4'b0001, S5);
    step_to(18); check_pins("t3_d1", 4'b0010, S4);
    step_to(34); check_pins("t3_d2", 4'b0100, 7'b0);
    step_to(50); check_pins("t3_d3", 4'b1000, 7'b0);
    step_to(52); pulse_load(16'h0000);
    wait_fs(n);
    step_to(2);  check_pins("t3_zero_d0", 4'b0001, S0);
    step_to(18); check_pins("t3_zero_d1", 4'b0010, 7'b0);

    // Overwritten pending load, then a load on the boundary cycle
    step_to(20); lz_blank = 1'b0; ack_cnt = 0;
    step_to(25); pulse_load(16'h1111);
    step_to(40); pulse_load(16'h2222);
    wait_fs(n);
    check("t4_ack", 32'(load_ack), 32'd1);
    step_to(2);  check_pins("t4_d0", 4'b0001, S2);
    step_to(18); check_pins("t4_d1", 4'b0010, S2);
    step_to(62); pulse_load(16'h0007);
    check("t4_ack_count", 32'(ack_cnt), 32'd1);
    wait_fs(n);
    check("t4_bnd_ack", 32'(load_ack), 32'd1);
    step_to(2);  check_pins("t4_bnd_d0", 4'b0001, S7);
    step_to(18); check_pins("t4_bnd_d1", 4'b0010, S0);
    wait_fs(n);
    check("t4_no_stale_ack", 32'(load_ack), 32'd0);

    // Display disabled: pins dark, frame timing unchanged
    display_en = 1'b0;
    lit_acc = '0;
    wait_fs(n); check("t5_period_1", 32'(n), 32'd64);
    wait_fs(n); check("t5_period_2", 32'(n), 32'd64);
    check("t5_dark", 32'(lit_acc), 32'd0);

    // Asynchronous reset mid-frame
    display_en = 1'b1;
    step_to(37); check_pins("t6_pre", 4'b0100, S0);
    reset = 1'b1;
    #1;
    check_pins("t6_in_reset", 4'b0000, 7'b0);
    check("t6_fs_reset", 32'(frame_start), 32'd0);
    check("t6_ack_reset", 32'(load_ack), 32'd0);
    step(); step();
    reset = 1'b0;
    wait_fs(n);
    check("t6_fs_latency", 32'(n), 32'd1);
    step_to(2);  check_pins("t6_d0", 4'b0001, S0);
    step_to(18); check_pins("t6_d1", 4'b0010, S0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
